// File: rtl/jtag_pkg.sv
// Shared types and constants for the multi-register JTAG TAP:
// the TAP state encoding, the fixed opcodes and the BYPASS opcode helper.
package jtag_pkg;

    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR        = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR        = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_t;

    localparam int OP_IDCODE    = 1;
    localparam int OP_USER_BASE = 2;

    // BYPASS is the all-ones instruction for the given IR width
    function automatic int bypass_op(input int ir_size);
        return (1 << ir_size) - 1;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller: state register and TMS-driven next-state logic only.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       i_tck,
    input  logic       i_trst_n,
    input  logic       i_tms,
    output tap_state_t o_state
);

    tap_state_t r_state;
    tap_state_t w_next;

    // State register with synchronous active-low reset
    always_ff @(posedge i_tck) begin
        if (!i_trst_n) begin
            r_state <= TEST_LOGIC_RESET;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode on TMS
    always_comb begin
        w_next = r_state;
        case (r_state)
            TEST_LOGIC_RESET: w_next = i_tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    w_next = i_tms ? SELECT_DR : RUN_TEST_IDLE;
            SELECT_DR:        w_next = i_tms ? SELECT_IR : CAPTURE_DR;
            CAPTURE_DR:       w_next = i_tms ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR:         w_next = i_tms ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR:         w_next = i_tms ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:         w_next = i_tms ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR:         w_next = i_tms ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR:        w_next = i_tms ? SELECT_DR : RUN_TEST_IDLE;
            SELECT_IR:        w_next = i_tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       w_next = i_tms ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR:         w_next = i_tms ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR:         w_next = i_tms ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:         w_next = i_tms ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR:         w_next = i_tms ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR:        w_next = i_tms ? SELECT_DR : RUN_TEST_IDLE;
            default:          w_next = TEST_LOGIC_RESET;
        endcase
    end

    assign o_state = r_state;

endmodule

// File: rtl/jtag_tap_multi.sv
// JTAG TAP with parametrised IR, BYPASS, IDCODE and NUM_USER_DR user data
// registers, each with core capture input, held parallel output and update strobe.
module jtag_tap_multi
    import jtag_pkg::*;
#(
    parameter int          IR_SIZE      = 4,
    parameter int          DR_SIZE      = 32,
    parameter int          NUM_USER_DR  = 2,
    parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001,
    parameter int          STATE_SIZE   = 4
) (
    input  logic                           TCK,
    input  logic                           TRST_N,
    input  logic                           TMS,
    input  logic                           TDI,
    output logic                           TDO,
    output logic                           TDO_EN,
    input  logic [NUM_USER_DR*DR_SIZE-1:0] USER_DR_IN,
    output logic [NUM_USER_DR*DR_SIZE-1:0] USER_DR_OUT,
    output logic [NUM_USER_DR-1:0]         USER_UPDATE,
    output logic [IR_SIZE-1:0]             IR_OUT,
    output logic [STATE_SIZE-1:0]          TAP_STATE
);

    localparam logic [IR_SIZE-1:0] OP_BYPASS = IR_SIZE'(bypass_op(IR_SIZE));

    tap_state_t                           w_state;
    logic [NUM_USER_DR-1:0][DR_SIZE-1:0]  w_user_in;
    logic [NUM_USER_DR-1:0]               w_sel_user;
    logic                                 w_sel_idcode;
    logic                                 w_sel_bypass;
    logic                                 w_dr_lsb;

    logic [IR_SIZE-1:0]                   r_ir_sr;
    logic [IR_SIZE-1:0]                   r_ir_out;
    logic                                 r_bypass;
    logic [31:0]                          r_idcode_sr;
    logic [NUM_USER_DR-1:0][DR_SIZE-1:0]  r_user_sr;
    logic [NUM_USER_DR-1:0][DR_SIZE-1:0]  r_user_out;
    logic [NUM_USER_DR-1:0]               r_user_upd;
    logic                                 r_tdo;
    logic                                 r_tdo_en;

    jtag_tap_fsm u_fsm (
        .i_tck    (TCK),
        .i_trst_n (TRST_N),
        .i_tms    (TMS),
        .o_state  (w_state)
    );

    assign w_user_in = USER_DR_IN;

    // Instruction decode; any opcode that is not IDCODE or a user slot falls back to BYPASS
    always_comb begin
        w_sel_idcode = (r_ir_out == IR_SIZE'(OP_IDCODE));
        for (int k = 0; k < NUM_USER_DR; k++) begin
            w_sel_user[k] = (r_ir_out == IR_SIZE'(OP_USER_BASE + k));
        end
        w_sel_bypass = (r_ir_out == OP_BYPASS) | ~(w_sel_idcode | (|w_sel_user));
    end

    // LSB of the currently selected data register feeds TDO
    always_comb begin
        w_dr_lsb = r_bypass;
        for (int k = 0; k < NUM_USER_DR; k++) begin
            w_dr_lsb = w_sel_user[k] ? r_user_sr[k][0] : w_dr_lsb;
        end
        w_dr_lsb = w_sel_idcode ? r_idcode_sr[0] : w_dr_lsb;
    end

    // IR, data registers, parallel outputs and TDO, all acting on the current TAP state
    always_ff @(posedge TCK) begin
        if (!TRST_N) begin
            r_ir_sr     <= '0;
            r_ir_out    <= IR_SIZE'(OP_IDCODE);
            r_bypass    <= 1'b0;
            r_idcode_sr <= 32'h0000_0000;
            r_user_sr   <= '0;
            r_user_out  <= '0;
            r_user_upd  <= '0;
            r_tdo       <= 1'b0;
            r_tdo_en    <= 1'b0;
        end else begin
            r_user_upd <= '0;
            r_tdo_en   <= (w_state == SHIFT_DR) || (w_state == SHIFT_IR);
            case (w_state)
                TEST_LOGIC_RESET: r_ir_out <= IR_SIZE'(OP_IDCODE);
                CAPTURE_IR:       r_ir_sr  <= IR_SIZE'(2'b01);
                SHIFT_IR: begin
                    r_tdo   <= r_ir_sr[0];
                    r_ir_sr <= {TDI, r_ir_sr[IR_SIZE-1:1]};
                end
                UPDATE_IR:        r_ir_out <= r_ir_sr;
                CAPTURE_DR: begin
                    if (w_sel_bypass) r_bypass <= 1'b0;
                    if (w_sel_idcode) r_idcode_sr <= IDCODE_VALUE;
                    for (int k = 0; k < NUM_USER_DR; k++) begin
                        if (w_sel_user[k]) r_user_sr[k] <= w_user_in[k];
                    end
                end
                SHIFT_DR: begin
                    r_tdo <= w_dr_lsb;
                    if (w_sel_bypass) r_bypass <= TDI;
                    if (w_sel_idcode) r_idcode_sr <= {TDI, r_idcode_sr[31:1]};
                    // shift form works for DR_SIZE == 1 as well
                    for (int k = 0; k < NUM_USER_DR; k++) begin
                        if (w_sel_user[k]) begin
                            r_user_sr[k] <= (r_user_sr[k] >> 1) | (DR_SIZE'(TDI) << (DR_SIZE - 1));
                        end
                    end
                end
                UPDATE_DR: begin
                    for (int k = 0; k < NUM_USER_DR; k++) begin
                        if (w_sel_user[k]) begin
                            r_user_out[k] <= r_user_sr[k];
                            r_user_upd[k] <= 1'b1;
                        end
                    end
                end
                default: r_tdo <= r_tdo;
            endcase
        end
    end

    assign TDO         = r_tdo;
    assign TDO_EN      = r_tdo_en;
    assign USER_DR_OUT = r_user_out;
    assign USER_UPDATE = r_user_upd;
    assign IR_OUT      = r_ir_out;
    assign TAP_STATE   = STATE_SIZE'(w_state);

endmodule

// File: doc/jtag_tap_multi.md
# jtag_tap_multi

Parametrised IEEE 1149.1-style TAP controller: a 16-state TAP FSM with configurable IR width, mandatory BYPASS and IDCODE registers, and NUM_USER_DR user data registers of configurable width. Each user register has a capture input from the core and a held parallel output with a one-cycle update strobe. It is the next-generation replacement for the fixed 32-bit single-DR `jtag` block and sits between the board-level TCK/TMS/TDI/TDO pins and on-chip debug/config logic.

## Interface
Parameters:
- IR_SIZE, 4: instruction register width; ≥ 2.
- DR_SIZE, 32: width of each user data register; ≥ 1.
- NUM_USER_DR, 2: number of user data registers; 1 ≤ NUM_USER_DR ≤ 2^IR_SIZE − 3.
- IDCODE_VALUE, 32'h1000_0001: value captured by IDCODE; bit 0 must be 1.
- STATE_SIZE, 4: TAP state encoding width; fixed at 4.

Ports:
- TCK  in  1  sole clock; all logic on rising edge.
- TRST_N  in  1  reset, synchronous, active-low.
- TMS  in  1  TAP mode select, sampled on rising TCK.
- TDI  in  1  serial data in.
- TDO  out  1  serial data out, registered.
- TDO_EN  out  1  high while the state is SHIFT_IR or SHIFT_DR (registered alongside TDO).
- USER_DR_IN  in  NUM_USER_DR*DR_SIZE  capture values; slice k = [k*DR_SIZE +: DR_SIZE].
- USER_DR_OUT  out  NUM_USER_DR*DR_SIZE  held parallel register values, same slicing.
- USER_UPDATE  out  NUM_USER_DR  one-cycle strobe per register on update.
- IR_OUT  out  IR_SIZE  current latched instruction.
- TAP_STATE  out  STATE_SIZE  current TAP state, for debug.

## Operation
- FSM states: TEST_LOGIC_RESET, RUN_TEST_IDLE, SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR, plus the six IR equivalents. Standard 1149.1 transitions on TMS. Five TMS=1 edges reach TEST_LOGIC_RESET from any state.
- Opcodes: all-ones = BYPASS; 1 = IDCODE; 2+k = USER_DR k (k < NUM_USER_DR). Every other value selects BYPASS.
- Active DR length: BYPASS 1 bit, IDCODE 32 bits, USER k DR_SIZE bits.
- Capture-IR: IR shift register loads {0…0, 2'b01}. Capture-DR: BYPASS loads 0; IDCODE loads IDCODE_VALUE; USER k loads USER_DR_IN slice k.
- Shift: the active shift register shifts right. TDI enters the MSB of that register's length, and the LSB is shifted out.
- Update-IR: IR_OUT is loaded from the IR shift register. Update-DR with USER k selected: USER_DR_OUT slice k is loaded from the shift register and USER_UPDATE[k] pulses. Update-DR with BYPASS or IDCODE selected has no parallel effect.
- In TEST_LOGIC_RESET, IR_OUT is forced to IDCODE.

## Timing
- TRST_N low at a rising edge gives, after that edge: state TEST_LOGIC_RESET, IR_OUT = 1, all shift registers 0, USER_DR_OUT 0, USER_UPDATE 0, TDO 0, TDO_EN 0. This holds for reset asserted mid-shift too: partially shifted data is discarded and USER_DR_OUT is cleared.
- Actions occur on the rising edge at which TAP_STATE equals the action state:
  - capture at the edge while in CAPTURE_*;
  - one shift per edge while in SHIFT_*, including the edge leaving with TMS=1;
  - update at the edge while in UPDATE_*.
- TDO: on each edge in SHIFT_*, TDO ← LSB of the active register before the shift. In all other states TDO holds its value.
- USER_UPDATE[k]: high for exactly the one cycle after the UPDATE_DR edge. USER_DR_OUT changes on that same edge.
- PAUSE_* holds the shift register contents unchanged. The shift count across PAUSE_* is cumulative.
- Shifting more than the register length: earlier TDI bits fall out through TDO, and the last N TDI bits remain.

## Structure
- Package `jtag_pkg` holds:
  - the tap_state_t enum (4-bit encoding);
  - opcode constants OP_IDCODE and OP_USER_BASE;
  - the BYPASS all-ones function of IR_SIZE.
- Sub-module `jtag_tap_fsm` contains only the state register and next-state logic. Its inputs are TCK, TRST_N and TMS; its output is the state.
- The top level holds the IR, DR muxing, shift registers and TDO.

## Test plan
- TRST_N low for 1 cycle from SHIFT_DR mid-shift → TAP_STATE = TEST_LOGIC_RESET, IR_OUT = 1, USER_DR_OUT = 0, TDO = 0.
- TMS=1×5, then TMS=0 (RUN_TEST_IDLE), then enter SHIFT_DR and shift 32 bits → TDO emits 32'h1000_0001, LSB first.
- Load IR with 4'hF and shift 8 bits of TDI pattern 8'b1011_0010 → TDO reproduces the pattern with 1-bit delay after the captured 0.
- Load IR with 2 (USER 0), USER_DR_IN slice 0 = 32'hCAFE_F00D, shift 32'h1234_5678 in → TDO emits 32'hCAFE_F00D. After UPDATE_DR: USER_DR_OUT slice 0 = 32'h1234_5678, USER_UPDATE = 2'b01 for one cycle, slice 1 unchanged.
- Shift-IR of 4'b0011 → TDO returns 4'b0001 (captured 01). After Update-IR, IR_OUT = 3 (USER 1).
- Enter PAUSE_DR after 16 bits, stay 5 cycles, resume and finish 16 bits → USER 1 updates to the full 32-bit value. Unused opcode 4'h9 → 1-bit bypass behaviour.
